// File: rtl/irq_snapshot_master.sv
// irq_snapshot_master
// APB read master for the interrupt/counter slave. When the slave raises irq
// it reads NUM_REGS counters one at a time and offers each one as an indexed
// word on a valid/ready stream. Once the last word is taken it pulses ack_out
// into the slave, then waits for irq to fall (bounded by IRQ_TIMEOUT) before
// it will service the next interrupt.
`timescale 1ns/1ps
module irq_snapshot_master #(
    parameter int unsigned NUM_REGS    = 10,
    parameter logic [31:0] FIRST_ADDR  = 32'h10,
    parameter int unsigned STRIDE      = 4,
    parameter int unsigned IRQ_TIMEOUT = 1024
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        enable,
    input  logic        irq_in,
    output logic        ack_out,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr,
    output logic [31:0] snap_data,
    output logic [3:0]  snap_idx,
    output logic        snap_last,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic        busy,
    output logic [1:0]  err_sticky,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        PUSH     = 3'd3,
        ACK      = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [15:0] TCNT_MAX = 16'(IRQ_TIMEOUT - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [15:0] tcnt;
    logic        set_slverr;
    logic        set_timeout;

    // Counter address for a given index; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] addr_of(input logic [3:0] i);
        return FIRST_ADDR + (32'(i) * 32'(STRIDE));
    endfunction

    // Read-only master: write channel is permanently inactive.
    assign m_pwrite = 1'b0;
    assign m_pwdata = 32'd0;
    assign busy     = (state != IDLE);

    // Error events, raised in the cycle they are detected.
    always_comb begin
        set_slverr  = (state == ACCESS) && m_pready && m_pslverr;
        set_timeout = (state == WAIT_LOW) && irq_in && (tcnt == TCNT_MAX);
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins per bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_sticky <= 2'b00;
        end else begin
            err_sticky <= (err_sticky & {2{~err_clr}}) | {set_timeout, set_slverr};
        end
    end

    // Service sequencer: APB read, stream push, acknowledge, wait for irq release.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            idx        <= 4'd0;
            tcnt       <= 16'd0;
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            m_paddr    <= 32'd0;
            snap_data  <= 32'd0;
            snap_idx   <= 4'd0;
            snap_last  <= 1'b0;
            snap_valid <= 1'b0;
            ack_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && irq_in) begin
                        idx     <= 4'd0;
                        m_paddr <= addr_of(4'd0);
                        m_psel  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    m_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // Data is captured even on PSLVERR; the error is only flagged.
                    if (m_pready) begin
                        snap_data  <= m_prdata;
                        snap_idx   <= idx;
                        snap_last  <= (idx == LAST_IDX);
                        snap_valid <= 1'b1;
                        m_psel     <= 1'b0;
                        m_penable  <= 1'b0;
                        state      <= PUSH;
                    end
                end
                PUSH: begin
                    if (snap_ready) begin
                        snap_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            ack_out <= 1'b1;
                            state   <= ACK;
                        end else begin
                            idx     <= idx + 4'd1;
                            m_paddr <= addr_of(idx + 4'd1);
                            m_psel  <= 1'b1;
                            state   <= SETUP;
                        end
                    end
                end
                ACK: begin
                    ack_out <= 1'b0;
                    tcnt    <= 16'd0;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // A stuck irq is abandoned after IRQ_TIMEOUT cycles (flagged above).
                    if (!irq_in || (tcnt == TCNT_MAX)) begin
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    m_psel     <= 1'b0;
                    m_penable  <= 1'b0;
                    snap_valid <= 1'b0;
                    ack_out    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_snapshot_master.sv
// Directed testbench for irq_snapshot_master with a zero-wait APB slave model
// whose read data is derived from the address.
`timescale 1ns/1ps
module tb_irq_snapshot_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        enable = 1'b0;
    logic        irq_in = 1'b0;
    logic        ack_out;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready = 1'b1;
    logic        m_pslverr;
    logic [31:0] snap_data;
    logic [3:0]  snap_idx;
    logic        snap_last;
    logic        snap_valid;
    logic        snap_ready = 1'b1;
    logic        busy;
    logic [1:0]  err_sticky;
    logic        err_clr = 1'b0;

    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    int assertions = 0;
    int failures = 0;

    irq_snapshot_master #(
        .NUM_REGS(10), .FIRST_ADDR(32'h10), .STRIDE(4), .IRQ_TIMEOUT(8)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .irq_in(irq_in),
        .ack_out(ack_out), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .snap_data(snap_data), .snap_idx(snap_idx), .snap_last(snap_last),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .busy(busy),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    initial forever #5 PCLK = ~PCLK;

    // Slave model
    assign m_prdata  = 32'hDA7A_0000 | m_paddr;
    assign m_pslverr = err_en && m_psel && m_penable && (m_paddr == err_addr);

    function automatic logic [31:0] exp_addr(input int i);
        return 32'h10 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return 32'hDA7A_0000 | exp_addr(i);
    endfunction

    // Recorder of stream words, APB accesses and acks
    logic        clr_rec = 1'b1;
    int          cyc = 0;
    int          nw = 0;
    int          na = 0;
    int          nack = 0;
    int          ack_cyc = 0;
    int          psel_cnt = 0;
    int          psel_bad = 0;
    logic [31:0] rec_data [16];
    logic [3:0]  rec_idx  [16];
    logic        rec_last [16];
    logic [31:0] rec_addr [16];

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (clr_rec) begin
            nw <= 0; na <= 0; nack <= 0; psel_cnt <= 0; psel_bad <= 0;
        end else begin
            if (snap_valid && snap_ready && nw < 16) begin
                rec_data[nw] <= snap_data;
                rec_idx[nw]  <= snap_idx;
                rec_last[nw] <= snap_last;
                nw <= nw + 1;
            end
            if (m_psel && m_penable && m_pready && na < 16) begin
                rec_addr[na] <= m_paddr;
                na <= na + 1;
            end
            if (ack_out) begin
                nack <= nack + 1;
                ack_cyc <= cyc;
            end
            if (m_psel) psel_cnt <= psel_cnt + 1;
            if (m_psel && (snap_valid || ack_out)) psel_bad <= psel_bad + 1;
        end
    end

    task automatic clear_rec();
        clr_rec = 1'b1;
        @(negedge PCLK);
        clr_rec = 1'b0;
    endtask

    task automatic run_to_ack(output bit ok);
        int n = 0;
        while (!ack_out && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        ok = ack_out;
    endtask

    task automatic wait_word(input int i, output bit ok);
        int n = 0;
        while (!(snap_valid && snap_idx == 4'(i)) && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        ok = snap_valid && (snap_idx == 4'(i));
    endtask

    task automatic test_reset();
        repeat (2) @(negedge PCLK);
        assertions++;
        if ({m_psel, m_penable, snap_valid, ack_out, busy, m_pwrite} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {m_psel, m_penable, snap_valid, ack_out, busy, m_pwrite});
        end
        assertions++;
        if (m_paddr !== 32'h0 || snap_data !== 32'h0 || m_pwdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: paddr %h snap_data %h pwdata %h required 0",
                     m_paddr, snap_data, m_pwdata);
        end
        assertions++;
        if (snap_idx !== 4'h0 || err_sticky !== 2'b00 || snap_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_idx_err: idx %h err %b last %b required 0", snap_idx, err_sticky, snap_last);
        end
        PRESETn = 1'b1;
        clear_rec();
    endtask

    task automatic test_full_service();
        bit ok;
        int c0;
        enable = 1'b1;
        c0 = cyc;
        irq_in = 1'b1;
        @(negedge PCLK);
        assertions++;
        if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h10) begin
            failures++;
            $display("FAIL setup_phase: psel %b penable %b paddr %h required 1 0 00000010", m_psel, m_penable, m_paddr);
        end
        @(negedge PCLK);
        assertions++;
        if (m_psel !== 1'b1 || m_penable !== 1'b1) begin
            failures++;
            $display("FAIL access_phase: psel %b penable %b required 1 1", m_psel, m_penable);
        end
        @(negedge PCLK);
        assertions++;
        if (snap_valid !== 1'b1 || snap_data !== exp_data(0) || m_psel !== 1'b0) begin
            failures++;
            $display("FAIL first_word: valid %b data %h psel %b required 1 %h 0", snap_valid, snap_data, m_psel, exp_data(0));
        end
        run_to_ack(ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL full_ack_seen: got 0 required 1");
        end
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (nw !== 10 || na !== 10 || nack !== 1) begin
            failures++;
            $display("FAIL full_counts: words %0d accesses %0d acks %0d required 10 10 1", nw, na, nack);
        end
        assertions++;
        if (ack_cyc - c0 !== 31) begin
            failures++;
            $display("FAIL ack_latency: got %0d required 31", ack_cyc - c0);
        end
        for (int i = 0; i < 10; i++) begin
            assertions++;
            if (rec_idx[i] !== 4'(i) || rec_data[i] !== exp_data(i) ||
                rec_last[i] !== (i == 9) || rec_addr[i] !== exp_addr(i)) begin
                failures++;
                $display("FAIL full_word%0d: idx %h data %h last %b addr %h required %h %h %b %h",
                         i, rec_idx[i], rec_data[i], rec_last[i], rec_addr[i],
                         4'(i), exp_data(i), (i == 9), exp_addr(i));
            end
        end
        assertions++;
        if (busy !== 1'b0 || psel_bad !== 0 || err_sticky !== 2'b00) begin
            failures++;
            $display("FAIL full_end: busy %b psel_bad %0d err %b required 0 0 00", busy, psel_bad, err_sticky);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_rec();
        irq_in = 1'b1;
        wait_word(3, ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_reach_idx3: got 0 required 1");
        end
        snap_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            assertions++;
            if (snap_valid !== 1'b1 || snap_idx !== 4'd3 || snap_data !== exp_data(3) || m_psel !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid %b idx %h data %h psel %b required 1 3 %h 0",
                         k, snap_valid, snap_idx, snap_data, m_psel, exp_data(3));
            end
        end
        snap_ready = 1'b1;
        run_to_ack(ok);
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (!ok || nw !== 10 || nack !== 1 || psel_bad !== 0) begin
            failures++;
            $display("FAIL bp_complete: ack %b words %0d acks %0d psel_bad %0d required 1 10 1 0", ok, nw, nack, psel_bad);
        end
        for (int i = 0; i < 10; i++) begin
            assertions++;
            if (rec_idx[i] !== 4'(i) || rec_data[i] !== exp_data(i)) begin
                failures++;
                $display("FAIL bp_word%0d: idx %h data %h required %h %h", i, rec_idx[i], rec_data[i], 4'(i), exp_data(i));
            end
        end
    endtask

    task automatic test_pslverr();
        bit ok;
        err_en = 1'b1;
        err_addr = 32'h1C;
        clear_rec();
        irq_in = 1'b1;
        run_to_ack(ok);
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (!ok || err_sticky !== 2'b01 || nw !== 10) begin
            failures++;
            $display("FAIL slverr_flag: ack %b err %b words %0d required 1 01 10", ok, err_sticky, nw);
        end
        assertions++;
        if (rec_idx[3] !== 4'd3 || rec_data[3] !== exp_data(3)) begin
            failures++;
            $display("FAIL slverr_word: idx %h data %h required 3 %h", rec_idx[3], rec_data[3], exp_data(3));
        end
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        assertions++;
        if (err_sticky !== 2'b00) begin
            failures++;
            $display("FAIL slverr_clear: got %b required 00", err_sticky);
        end
        // Clear held while the error recurs: set must win on that edge.
        err_clr = 1'b1;
        irq_in = 1'b1;
        wait_word(3, ok);
        assertions++;
        if (!ok || err_sticky !== 2'b01) begin
            failures++;
            $display("FAIL set_beats_clr: reached %b err %b required 1 01", ok, err_sticky);
        end
        @(negedge PCLK);
        assertions++;
        if (err_sticky !== 2'b00) begin
            failures++;
            $display("FAIL clr_after_set: got %b required 00", err_sticky);
        end
        err_clr = 1'b0;
        run_to_ack(ok);
        irq_in = 1'b0;
        err_en = 1'b0;
        repeat (3) @(negedge PCLK);
    endtask

    task automatic test_timeout();
        bit ok;
        clear_rec();
        irq_in = 1'b1;
        run_to_ack(ok);
        assertions++;
        if (!ok) begin
            failures++;
            $display("FAIL to_first_ack: got 0 required 1");
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge PCLK);
            assertions++;
            if (busy !== 1'b1 || err_sticky !== 2'b00) begin
                failures++;
                $display("FAIL to_wait%0d: busy %b err %b required 1 00", k, busy, err_sticky);
            end
        end
        @(negedge PCLK);
        assertions++;
        if (err_sticky !== 2'b10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_flag: err %b busy %b required 10 0", err_sticky, busy);
        end
        clear_rec();
        assertions++;
        if (m_psel !== 1'b1 || m_paddr !== 32'h10) begin
            failures++;
            $display("FAIL to_reservice: psel %b paddr %h required 1 00000010", m_psel, m_paddr);
        end
        run_to_ack(ok);
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (!ok || nw !== 10 || nack !== 1 || err_sticky !== 2'b10) begin
            failures++;
            $display("FAIL to_second: ack %b words %0d acks %0d err %b required 1 10 1 10", ok, nw, nack, err_sticky);
        end
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
    endtask

    task automatic test_enable();
        bit ok;
        enable = 1'b0;
        irq_in = 1'b1;
        clear_rec();
        repeat (20) @(negedge PCLK);
        assertions++;
        if (psel_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL en_off: psel cycles %0d busy %b required 0 0", psel_cnt, busy);
        end
        enable = 1'b1;
        wait_word(4, ok);
        enable = 1'b0;
        run_to_ack(ok);
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (!ok || nw !== 10 || nack !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL en_drop: ack %b words %0d acks %0d busy %b required 1 10 1 0", ok, nw, nack, busy);
        end
        assertions++;
        if (rec_idx[9] !== 4'd9 || rec_last[9] !== 1'b1) begin
            failures++;
            $display("FAIL en_last: idx %h last %b required 9 1", rec_idx[9], rec_last[9]);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        irq_in = 1'b1;
        while (!(m_psel && m_penable && m_paddr == exp_addr(5)) && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        assertions++;
        if (!(m_psel && m_penable && m_paddr == exp_addr(5))) begin
            failures++;
            $display("FAIL rst_reach_access5: got 0 required 1");
        end
        PRESETn = 1'b0;
        #1;
        assertions++;
        if ({m_psel, m_penable, snap_valid, ack_out, busy} !== 5'b0 ||
            m_paddr !== 32'h0 || snap_data !== 32'h0 || snap_idx !== 4'h0 || err_sticky !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_outputs: ctrl %b paddr %h data %h idx %h err %b required 0",
                     {m_psel, m_penable, snap_valid, ack_out, busy}, m_paddr, snap_data, snap_idx, err_sticky);
        end
        clear_rec();
        @(negedge PCLK);
        assertions++;
        if (nack !== 0 || ack_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_ack: acks %0d ack_out %b required 0 0", nack, ack_out);
        end
        PRESETn = 1'b1;
        run_to_ack(ok);
        irq_in = 1'b0;
        repeat (3) @(negedge PCLK);
        assertions++;
        if (!ok || nw !== 10 || rec_idx[0] !== 4'd0 || rec_addr[0] !== 32'h10) begin
            failures++;
            $display("FAIL rst_restart: ack %b words %0d idx0 %h addr0 %h required 1 10 0 00000010",
                     ok, nw, rec_idx[0], rec_addr[0]);
        end
    endtask

    initial begin
        test_reset();
        test_full_service();
        test_backpressure();
        test_pslverr();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
